ex_stage: RTL and testbench



---
 rtl/ex_stage.sv | 156 +++++++++++++++
 tb/tb_ex_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, ALU, EX/MEM register.
// Feeds both decode forwarding paths from registered state only.

package ex_pkg;

    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_SLTIU_OP = 8'b0101_1000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;

    localparam logic [2:0] EXE_RES_NOP        = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

    localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
    } id_ex_t;

    typedef struct packed {
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        wreg;
    } ex_mem_t;

    localparam id_ex_t ID_EX_NOP = '{
        aluop:  EXE_NOP_OP,
        alusel: EXE_RES_NOP,
        reg1:   32'd0,
        reg2:   32'd0,
        wd:     NOP_REG_ADDR,
        wreg:   1'b0
    };

    localparam ex_mem_t EX_MEM_NOP = '{
        wd:    NOP_REG_ADDR,
        wdata: 32'd0,
        wreg:  1'b0
    };

endpackage

module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_id_i,
    input  logic        stall_ex_i,
    input  logic        stall_mem_i,
    input  logic        flush_i,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  ex_wd_o,
    output logic [31:0] ex_wdata_o,
    output logic        ex_wreg_o,
    output logic [4:0]  mem_wd_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_wreg_o
);

    id_ex_t      id_ex;
    ex_mem_t     ex_mem;
    logic [31:0] arith_res;
    logic [31:0] logic_res;

    // ID/EX register: flush, then decode bubble, then capture, else hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex <= ID_EX_NOP;
        end else if (flush_i) begin
            id_ex <= ID_EX_NOP;
        end else if (stall_id_i && !stall_ex_i) begin
            id_ex <= ID_EX_NOP;
        end else if (!stall_id_i) begin
            id_ex <= '{
                aluop:  aluop_i,
                alusel: alusel_i,
                reg1:   reg1_i,
                reg2:   reg2_i,
                wd:     wd_i,
                wreg:   wreg_i
            };
        end
    end

    // Compare/add/sub and bitwise results from latched operands
    always_comb begin
        arith_res = 32'd0;
        logic_res = 32'd0;
        case (id_ex.aluop)
            EXE_SLTU_OP,
            EXE_SLTIU_OP: arith_res = {31'd0, id_ex.reg1 < id_ex.reg2};
            EXE_SLT_OP:   arith_res = {31'd0, $signed(id_ex.reg1) < $signed(id_ex.reg2)};
            EXE_ADDU_OP:  arith_res = id_ex.reg1 + id_ex.reg2;
            EXE_SUBU_OP:  arith_res = id_ex.reg1 - id_ex.reg2;
            EXE_AND_OP:   logic_res = id_ex.reg1 & id_ex.reg2;
            EXE_OR_OP:    logic_res = id_ex.reg1 | id_ex.reg2;
            EXE_XOR_OP:   logic_res = id_ex.reg1 ^ id_ex.reg2;
            default: begin
                arith_res = 32'd0;
                logic_res = 32'd0;
            end
        endcase
    end

    // Result class select; unknown classes yield zero
    always_comb begin
        ex_wdata_o = 32'd0;
        case (id_ex.alusel)
            EXE_RES_ARITHMETIC: ex_wdata_o = arith_res;
            EXE_RES_LOGIC:      ex_wdata_o = logic_res;
            default:            ex_wdata_o = 32'd0;
        endcase
    end

    assign ex_wd_o   = id_ex.wd;
    assign ex_wreg_o = id_ex.wreg;

    // EX/MEM register: flush, then EX bubble, then capture, else hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_mem <= EX_MEM_NOP;
        end else if (flush_i) begin
            ex_mem <= EX_MEM_NOP;
        end else if (stall_ex_i && !stall_mem_i) begin
            ex_mem <= EX_MEM_NOP;
        end else if (!stall_ex_i) begin
            ex_mem <= '{
                wd:    ex_wd_o,
                wdata: ex_wdata_o,
                wreg:  ex_wreg_o
            };
        end
    end

    assign mem_wd_o    = ex_mem.wd;
    assign mem_wdata_o = ex_mem.wdata;
    assign mem_wreg_o  = ex_mem.wreg;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against an arithmetic reference model.
// Directed plan cases first, then random stalls/flushes/ops.

module tb_ex_stage;
    import ex_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall_id_i;
    logic        stall_ex_i;
    logic        stall_mem_i;
    logic        flush_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  ex_wd_o;
    logic [31:0] ex_wdata_o;
    logic        ex_wreg_o;
    logic [4:0]  mem_wd_o;
    logic [31:0] mem_wdata_o;
    logic        mem_wreg_o;

    int checks = 0;
    int errors = 0;

    // model state: instruction in EX, record in MEM
    logic [7:0]  m_op;
    logic [2:0]  m_sel;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [4:0]  m_wd;
    logic        m_wreg;
    logic [4:0]  m_mwd;
    logic [31:0] m_mdata;
    logic        m_mwreg;

    ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall_id_i  (stall_id_i),
        .stall_ex_i  (stall_ex_i),
        .stall_mem_i (stall_mem_i),
        .flush_i     (flush_i),
        .aluop_i     (aluop_i),
        .alusel_i    (alusel_i),
        .reg1_i      (reg1_i),
        .reg2_i      (reg2_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .ex_wd_o     (ex_wd_o),
        .ex_wdata_o  (ex_wdata_o),
        .ex_wreg_o   (ex_wreg_o),
        .mem_wd_o    (mem_wd_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wreg_o  (mem_wreg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference result: plain arithmetic, signed compare by sign-bit bias
    function automatic logic [31:0] ref_res(input logic [7:0] op,
                                            input logic [2:0] sel,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint ua, ub;
        ua = longint'(a);
        ub = longint'(b);
        if (sel == EXE_RES_ARITHMETIC) begin
            if (op == EXE_SLTU_OP || op == EXE_SLTIU_OP)
                return (ua < ub) ? 32'd1 : 32'd0;
            if (op == EXE_SLT_OP)
                return ((ua ^ 64'h8000_0000) < (ub ^ 64'h8000_0000)) ? 32'd1 : 32'd0;
            if (op == EXE_ADDU_OP)
                return 32'((ua + ub) % 64'h1_0000_0000);
            if (op == EXE_SUBU_OP)
                return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
            return 32'd0;
        end
        if (sel == EXE_RES_LOGIC) begin
            if (op == EXE_AND_OP) return a & b;
            if (op == EXE_OR_OP)  return a | b;
            if (op == EXE_XOR_OP) return a ^ b;
            return 32'd0;
        end
        return 32'd0;
    endfunction

    task automatic model_clear();
        m_op = 8'd0; m_sel = 3'd0; m_a = 0; m_b = 0; m_wd = 0; m_wreg = 0;
        m_mwd = 0; m_mdata = 0; m_mwreg = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ex_wd"},     32'(ex_wd_o),     32'(m_wd));
        chk({tag, ".ex_wdata"},  ex_wdata_o,       ref_res(m_op, m_sel, m_a, m_b));
        chk({tag, ".ex_wreg"},   32'(ex_wreg_o),   32'(m_wreg));
        chk({tag, ".mem_wd"},    32'(mem_wd_o),    32'(m_mwd));
        chk({tag, ".mem_wdata"}, mem_wdata_o,      m_mdata);
        chk({tag, ".mem_wreg"},  32'(mem_wreg_o),  32'(m_mwreg));
    endtask

    task automatic issue(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wr);
        aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b;
        wd_i = wd; wreg_i = wr;
    endtask

    task automatic set_ctl(input logic f, input logic sid,
                           input logic sex, input logic smem);
        flush_i = f; stall_id_i = sid; stall_ex_i = sex; stall_mem_i = smem;
    endtask

    // one clock edge: advance model with the inputs seen at the edge, then compare
    task automatic tick(input string tag);
        @(posedge clk);
        if (flush_i || (stall_ex_i && !stall_mem_i)) begin
            m_mwd = 0; m_mdata = 0; m_mwreg = 0;
        end else if (!stall_ex_i) begin
            m_mwd = m_wd; m_mdata = ref_res(m_op, m_sel, m_a, m_b); m_mwreg = m_wreg;
        end
        if (flush_i || (stall_id_i && !stall_ex_i)) begin
            m_op = EXE_NOP_OP; m_sel = EXE_RES_NOP; m_a = 0; m_b = 0;
            m_wd = 0; m_wreg = 0;
        end else if (!stall_id_i) begin
            m_op = aluop_i; m_sel = alusel_i; m_a = reg1_i; m_b = reg2_i;
            m_wd = wd_i; m_wreg = wreg_i;
        end
        #1;
        check_all(tag);
    endtask

    logic [7:0] ops [10];
    logic [2:0] sels [4];

    initial begin
        ops = '{EXE_NOP_OP, EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_SLT_OP,
                EXE_SLTU_OP, EXE_SLTIU_OP, EXE_ADDU_OP, EXE_SUBU_OP, 8'hFF};
        sels = '{EXE_RES_NOP, EXE_RES_LOGIC, EXE_RES_ARITHMETIC, 3'b111};

        // reset with nonzero inputs: outputs zero immediately
        set_ctl(0, 0, 0, 0);
        issue(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'h11, 32'h22, 5'd9, 1'b1);
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        model_clear();
        check_all("reset");
        #1 rst = 1'b1;

        // first capture after release
        issue(EXE_SLTIU_OP, EXE_RES_ARITHMETIC, 32'd5, 32'h0000_8000, 5'd3, 1'b1);
        tick("sltiu_ex");
        chk("sltiu_ex_val", ex_wdata_o, 32'd1);
        issue(EXE_NOP_OP, EXE_RES_NOP, 0, 0, 0, 0);
        tick("sltiu_mem");
        chk("sltiu_mem_val", mem_wdata_o, 32'd1);
        chk("sltiu_mem_wd", 32'(mem_wd_o), 32'd3);
        chk("sltiu_mem_wreg", 32'(mem_wreg_o), 32'd1);

        // signed vs unsigned
        issue(EXE_SLT_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1, 5'd1, 1'b1);
        tick("slt");  chk("slt_val", ex_wdata_o, 32'd1);
        issue(EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1, 5'd2, 1'b1);
        tick("sltu"); chk("sltu_val", ex_wdata_o, 32'd0);
        issue(EXE_SLTIU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1, 5'd2, 1'b1);
        tick("sltiu"); chk("sltiu_val", ex_wdata_o, 32'd0);
        issue(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
        tick("addu"); chk("addu_wrap", ex_wdata_o, 32'd0);
        issue(EXE_SUBU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
        tick("subu"); chk("subu_val", ex_wdata_o, 32'hFFFF_FFFE);

        // logic ops
        issue(EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6, 1'b1);
        tick("and"); chk("and_val", ex_wdata_o, 32'h00F0_00F0);
        issue(EXE_OR_OP, EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6, 1'b1);
        tick("or");  chk("or_val", ex_wdata_o, 32'hFFF0_FFF0);
        issue(EXE_XOR_OP, EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6, 1'b1);
        tick("xor"); chk("xor_val", ex_wdata_o, 32'hFF00_FF00);
        issue(8'hFF, EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6, 1'b1);
        tick("unk"); chk("unk_val", ex_wdata_o, 32'd0);

        // decode stall: bubble into EX, ADDU reaches MEM once
        issue(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'd3, 32'd4, 5'd7, 1'b1);
        tick("ds_issue");
        set_ctl(0, 1, 0, 0);
        issue(EXE_OR_OP, EXE_RES_LOGIC, 32'd1, 32'd2, 5'd8, 1'b1);
        tick("ds_bubble");
        chk("ds_ex_wreg", 32'(ex_wreg_o), 32'd0);
        chk("ds_ex_wd", 32'(ex_wd_o), 32'd0);
        chk("ds_mem_val", mem_wdata_o, 32'd7);
        set_ctl(0, 0, 0, 0);
        tick("ds_after");
        chk("ds_once", 32'(mem_wreg_o), 32'd0);

        // EX stall for two cycles
        issue(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'd10, 32'd20, 5'd5, 1'b1);
        tick("es_issue");
        set_ctl(0, 1, 1, 0);
        issue(EXE_XOR_OP, EXE_RES_LOGIC, 32'd9, 32'd9, 5'd11, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick("es_hold");
            chk("es_ex_held", ex_wdata_o, 32'd30);
            chk("es_mem_bub", 32'(mem_wreg_o), 32'd0);
        end
        set_ctl(0, 0, 0, 0);
        tick("es_release");
        chk("es_mem_val", mem_wdata_o, 32'd30);
        chk("es_mem_wd", 32'(mem_wd_o), 32'd5);
        tick("es_next");
        chk("es_no_dup", 32'(mem_wd_o), 32'd11);

        // flush dominates stalls
        issue(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'd1, 32'd1, 5'd12, 1'b1);
        tick("fl_issue");
        set_ctl(1, 1, 1, 1);
        tick("fl_edge");
        chk("fl_ex_wreg", 32'(ex_wreg_o), 32'd0);
        chk("fl_mem_wreg", 32'(mem_wreg_o), 32'd0);
        set_ctl(0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            set_ctl($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            issue(ops[$urandom_range(0, 9)], sels[$urandom_range(0, 3)],
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom(),
                  ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom(),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            tick("rand");
        end

        // reset mid-stall discards held instruction
        set_ctl(0, 0, 0, 0);
        issue(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'd40, 32'd2, 5'd13, 1'b1);
        tick("rs_issue");
        set_ctl(0, 1, 1, 1);
        tick("rs_stall");
        #2 rst = 1'b0;
        #1;
        model_clear();
        check_all("rs_reset");
        #1 rst = 1'b1;
        set_ctl(0, 1, 0, 0);
        tick("rs_after");
        chk("rs_no_resume", 32'(ex_wreg_o), 32'd0);
        set_ctl(0, 0, 0, 0);
        tick("rs_after2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
